// File: rtl/nibble_deserializer.sv
// nibble_deserializer: framed serial bits to 4-bit nibbles through a 2-entry valid/ready FIFO
module nibble_deserializer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  input  logic       sin_valid,
  input  logic       sin_start,
  output logic [3:0] out_nibble,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overflow
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [1:0] cnt, cnt_n, pos, occ;
  logic [3:0] sh, sh_n, tail;
  logic start, done, err, pop;
  assign start = sin_valid & sin_start;
  assign pop = out_valid & out_ready;
  assign out_valid = occ != 2'd0;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    done = 1'b0;
    err = 1'b0;
    pos = LSB_FIRST ? (start ? 2'd0 : cnt) : (start ? 2'd3 : ~cnt);
    if (start) begin
      err = state == SHIFT;
      sh_n = '0;
      sh_n[pos] = sin;
      cnt_n = 2'd1;
      state_n = SHIFT;
    end else if (sin_valid && state == SHIFT) begin
      sh_n[pos] = sin;
      cnt_n = cnt + 2'd1;
      done = cnt == 2'd3;
      state_n = done ? IDLE : SHIFT;
    end
  end
  // sh_n is the completed nibble on the cycle done is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      occ <= '0;
      tail <= '0;
      out_nibble <= '0;
      frame_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      frame_err <= err;
      if (done && occ == 2'd2 && !pop) overflow <= 1'b1;
      if (occ == 2'd0) begin
        if (done) begin
          out_nibble <= sh_n;
          occ <= 2'd1;
        end
      end else if (occ == 2'd1) begin
        if (done && pop) out_nibble <= sh_n;
        else if (done) begin
          tail <= sh_n;
          occ <= 2'd2;
        end else if (pop) occ <= 2'd0;
      end else if (pop) begin
        out_nibble <= tail;
        tail <= sh_n;
        if (!done) occ <= 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_nibble_deserializer.sv
// tb_nibble_deserializer: scoreboard bench driving LSB-first and MSB-first instances in parallel
module tb_nibble_deserializer;
  logic clk, rst_n, sin, sin_valid, sin_start, out_ready;
  logic [3:0] nib_l, nib_m;
  logic val_l, val_m, ferr_l, ferr_m, ovf_l, ovf_m;
  int checks, errors, err_l, err_m;
  logic [3:0] q_l[$], q_m[$];
  nibble_deserializer #(.LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
    .out_nibble(nib_l), .out_valid(val_l), .out_ready(out_ready), .frame_err(ferr_l), .overflow(ovf_l));
  nibble_deserializer #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
    .out_nibble(nib_m), .out_valid(val_m), .out_ready(out_ready), .frame_err(ferr_m), .overflow(ovf_m));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] rev(input logic [3:0] f);
    return {f[0], f[1], f[2], f[3]};
  endfunction
  always @(negedge clk) if (rst_n) begin
    if (ferr_l) err_l++;
    if (ferr_m) err_m++;
    if (val_l && out_ready) begin
      if (q_l.size() == 0) check("spur_pop_l", 0, 1);
      else check("nib_l", int'(nib_l), int'(q_l.pop_front()));
    end
    if (val_m && out_ready) begin
      if (q_m.size() == 0) check("spur_pop_m", 0, 1);
      else check("nib_m", int'(nib_m), int'(q_m.pop_front()));
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_bit(input logic b, input logic st);
    sin = b;
    sin_valid = 1'b1;
    sin_start = st;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sin_start = 1'b0;
  endtask
  task automatic send_frame(input logic [3:0] f, input bit expect_it, input int gap);
    if (expect_it) begin
      q_l.push_back(f);
      q_m.push_back(rev(f));
    end
    for (int k = 0; k < 4; k++) begin
      send_bit(f[k], k == 0);
      if (k < 3) idle(gap);
    end
  endtask
  initial begin
    int e0;
    checks = 0; errors = 0; err_l = 0; err_m = 0;
    rst_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; sin_start = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_valid", int'(val_l), 0);
    check("rst_nib", int'(nib_l), 0);
    check("rst_ferr", int'(ferr_l), 0);
    check("rst_ovf", int'(ovf_l), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_frame(4'b1101, 1'b1, 0);
    check("lat_valid", int'(val_l), 1);
    check("lat_nib_l", int'(nib_l), 'hD);
    check("lat_nib_m", int'(nib_m), 'hB);
    idle(1);
    check("drop_valid", int'(val_l), 0);
    out_ready = 1'b0;
    send_frame(4'h1, 1'b1, 0);
    send_frame(4'h2, 1'b1, 0);
    check("pre_ovf", int'(ovf_l), 0);
    send_frame(4'h3, 1'b0, 0);
    check("ovf_l", int'(ovf_l), 1);
    check("ovf_m", int'(ovf_m), 1);
    check("full_nib", int'(nib_l), 'h1);
    out_ready = 1'b1;
    idle(3);
    check("drain_valid", int'(val_l), 0);
    check("ovf_sticky", int'(ovf_l), 1);
    e0 = err_l;
    q_l.push_back(4'hD);
    q_m.push_back(4'hB);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    idle(2);
    check("ferr_once_l", err_l - e0, 1);
    check("ferr_m", err_m, err_l);
    e0 = err_l;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    idle(1);
    check("idle_novalid", int'(val_l), 0);
    check("idle_noerr", err_l - e0, 0);
    send_frame(4'b0110, 1'b1, 2);
    idle(2);
    check("gap_noerr", err_l - e0, 0);
    out_ready = 1'b0;
    send_frame(4'h9, 1'b1, 0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    check("pre_rst_valid", int'(val_l), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(val_l), 0);
    check("arst_ovf", int'(ovf_l), 0);
    check("arst_nib", int'(nib_l), 0);
    q_l.delete();
    q_m.delete();
    idle(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_frame(4'b1010, 1'b1, 0);
    check("post_rst_nib", int'(nib_l), 'hA);
    idle(3);
    check("q_l_empty", q_l.size(), 0);
    check("q_m_empty", q_m.size(), 0);
    check("final_ovf", int'(ovf_l), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nibble_deserializer.md
# nibble_deserializer

Serial-to-parallel front end that assembles framed serial bits into 4-bit vectors and presents them on a valid/ready interface. It sits directly upstream of the four-input reduction gate and supplies its 4-bit `in` vector. A 2-entry output FIFO absorbs consumer back-pressure. Framing errors and overflow are flagged.

## Interface
- `LSB_FIRST`, default 1: 1 = the first serial bit of a frame lands in `out_nibble[0]`; 0 = the first bit lands in `out_nibble[3]`.
- `clk`  input  1  rising-edge clock, the only clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `sin`  input  1  serial data bit, sampled when `sin_valid`=1.
- `sin_valid`  input  1  `sin` carries a bit this cycle.
- `sin_start`  input  1  marks the current bit as bit 0 of a new frame; ignored unless `sin_valid`=1.
- `out_nibble`  output  4  head-of-FIFO nibble; drives the gate's `in`.
- `out_valid`  output  1  FIFO non-empty.
- `out_ready`  input  1  consumer accepts the head when `out_valid`=1.
- `frame_err`  output  1  one-cycle pulse on a framing error.
- `overflow`  output  1  sticky flag: a completed nibble was dropped; cleared only by reset.

## Operation
- Clock is `clk`. Reset is asynchronous and active-low on `rst_n`. Reset drives:
  - `out_nibble`=0, `out_valid`=0, `frame_err`=0, `overflow`=0.
  - FSM to IDLE, bit counter to 0, FIFO to empty, shift register to 0.
- FSM states:
  - IDLE: a bit with `sin_valid`=1 and `sin_start`=1 is stored as bit 0, counter=1, go to SHIFT. A bit with `sin_valid`=1 and `sin_start`=0 is discarded silently, with no error.
  - SHIFT: a bit with `sin_valid`=1 and `sin_start`=0 is stored at the counter position and the counter increments. When the 4th bit is stored (counter reaches 4), the nibble is pushed, counter goes to 0, and the FSM goes to IDLE.
  - Cycles with `sin_valid`=0 hold all state, with no timeout.
- Framing error: `sin_valid`=1 and `sin_start`=1 while in SHIFT.
  - `frame_err` pulses for 1 cycle.
  - The partial frame is discarded.
  - The current bit becomes bit 0 of the new frame, counter=1, FSM stays in SHIFT.
- Bit placement:
  - `LSB_FIRST`=1: frame bit k goes to nibble bit k.
  - `LSB_FIRST`=0: frame bit k goes to nibble bit 3-k.
- FIFO: 2 entries.
  - Push occurs when a nibble completes.
  - Pop occurs when `out_valid` and `out_ready` are both 1.
- Push when full:
  - Without a pop in the same cycle: the nibble is dropped, `overflow` is set, and FIFO contents are unchanged.
  - With a pop in the same cycle: the push is accepted, no overflow, and occupancy stays at 2.
- Pop and push on an empty FIFO cannot coincide, because `out_valid`=0 when the FIFO is empty.
- `out_nibble` always shows the head entry. When the FIFO is empty, it holds its last value (0 after reset); consumers must qualify it with `out_valid`.

## Timing
- Latency: the 4th bit is sampled at edge N. `out_valid`=1 and `out_nibble` updated are visible after edge N, provided the FIFO was empty.
- Throughput: 1 nibble per 4 valid bits. Back-to-back frames are allowed: `sin_start` can arrive on the cycle right after a frame's 4th bit.
- Pop at edge M:
  - The next entry appears after edge M.
  - If the FIFO becomes empty, `out_valid`=0 after edge M.
- `out_valid` and `out_nibble` are registered outputs, with no combinational path from `out_ready`.
- `frame_err` is registered: it is high during the cycle after the offending bit's edge.
- `overflow` is set after the edge of the dropped push and stays high until `rst_n`=0.
- Reset mid-frame or with a non-empty FIFO: all state clears immediately and asynchronously. After `rst_n` rises, the first `sin_start` begins a fresh frame.

## Test plan
- Reset, then serial 1,0,1,1 with `sin_start` on the first bit, `LSB_FIRST`=1, `out_ready`=1 -> `out_nibble`=4'hD and `out_valid`=1 one cycle after the 4th bit. With `out_ready`=1, `out_valid` drops the next cycle.
- Same bits 1,0,1,1 with `LSB_FIRST`=0 -> `out_nibble`=4'hB.
- `out_ready`=0, then send three frames 4'h1, 4'h2, 4'h3 -> `overflow`=1 after the 3rd frame. Then assert `out_ready` -> pops give 4'h1 then 4'h2, `out_valid`=0 after that, and `overflow` stays 1.
- `sin_start` on the 3rd bit of a frame, then 3 more bits 0,1,1 with `LSB_FIRST`=1 -> `frame_err` pulses once, and the output is the single nibble 4'b1101 formed from the restarted frame (bits 1,0,1,1).
- `sin_valid` bits in IDLE without `sin_start` -> no push and no `frame_err`. Gaps of `sin_valid`=0 inside a frame -> nibble still correct.
- Assert `rst_n`=0 while 2 bits into a frame with 1 FIFO entry -> `out_valid`=0 and `overflow`=0 immediately. A new full frame after reset yields the correct nibble.
